// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared arbiter state type and index-width helper
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: requester bundle plus FIFO write-port signals
interface fifo_push_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    logic                          fifo_push;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic [idx_w(NUM_REQ)-1:0]     owner;
    logic                          owner_valid;

    modport master (
        output req, req_data, fifo_full,
        input  grant, fifo_push, fifo_data_in, owner, owner_valid
    );

    modport slave (
        input  req, req_data, fifo_full,
        output grant, fifo_push, fifo_data_in, owner, owner_valid
    );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: rotating-priority search starting just after ptr
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);
    logic [IW-1:0] c;

    // Walk farthest-to-nearest so the closest requester after ptr wins last.
    always_comb begin
        found = 1'b0;
        idx = '0;
        c = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[c]) begin
                found = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-limited sharing of one FIFO write port
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 2
) (
    input logic           clk,
    input logic           rst,
    fifo_push_arbiter_if.slave bus
);
    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t    state, state_nx;
    logic [IW-1:0] ptr, ptr_nx, owner, owner_nx, pick_ptr, win, gnt_idx;
    logic [BW-1:0] burst_cnt, burst_nx, bump;
    logic          found, hold_live, gnt_v;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .found (found),
        .idx   (win)
    );

    assign hold_live = state == ARB_HOLD && bus.req[owner];
    assign pick_ptr  = state == ARB_HOLD ? owner : ptr;
    assign gnt_idx   = hold_live ? owner : win;
    assign gnt_v     = !rst && !bus.fifo_full && (hold_live || found);
    assign bump      = burst_cnt + BW'(1);

    assign bus.grant        = gnt_v ? NUM_REQ'(1) << gnt_idx : '0;
    assign bus.fifo_push    = gnt_v;
    assign bus.fifo_data_in = gnt_v ? bus.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.owner_valid  = state == ARB_HOLD;
    assign bus.owner        = state == ARB_HOLD ? owner : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            ptr <= IW'(NUM_REQ - 1);
            owner <= '0;
            burst_cnt <= '0;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            owner <= owner_nx;
            burst_cnt <= burst_nx;
        end
    end

    // An owner that drops req hands over in the same cycle via a search from owner.
    always_comb begin
        state_nx = state;
        ptr_nx = ptr;
        owner_nx = owner;
        burst_nx = burst_cnt;
        if (!bus.fifo_full) begin
            if (hold_live) begin
                burst_nx = bump;
                if (bump == BW'(MAX_BURST)) begin
                    ptr_nx = owner;
                    burst_nx = '0;
                    state_nx = ARB_IDLE;
                end
            end else begin
                if (state == ARB_HOLD)
                    ptr_nx = owner;
                if (found) begin
                    burst_nx = BW'(1);
                    if (MAX_BURST == 1) begin
                        ptr_nx = win;
                    end else begin
                        owner_nx = win;
                        state_nx = ARB_HOLD;
                    end
                end else if (state == ARB_HOLD) begin
                    state_nx = ARB_IDLE;
                    burst_nx = '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: scoreboard bench with a 3-entry FIFO model and polling consumer
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) a ();
    fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) b ();

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    int         n_tests = 0;
    int         n_fail = 0;
    int         exp_a[$];
    int         exp_b[$];
    int         exp_out[$];
    logic [7:0] fq[$];
    logic       full_r = 1'b0;
    logic       poll = 1'b1;
    logic       pend_push = 1'b0;
    logic       pend_pop = 1'b0;
    logic [7:0] pend_data = '0;

    assign a.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    assign b.req_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    assign a.fifo_full = full_r;
    assign b.fifo_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ids are hex digits, first expected grant in the leftmost of n digits
    task automatic plan(input bit to_b, input int n, input logic [63:0] ids);
        int id;
        for (int i = 0; i < n; i++) begin
            id = int'(ids[4*(n-1-i) +: 4]);
            if (to_b) exp_b.push_back(id);
            else begin
                exp_a.push_back(id);
                exp_out.push_back(id);
            end
        end
    endtask

    always @(negedge clk) begin
        int e;
        chk("a_push_vs_grant", 32'(a.fifo_push), 32'(|a.grant));
        if (a.fifo_push) begin
            if (exp_a.size() == 0) chk("a_unexpected_push", 32'(a.grant), 32'h0);
            else begin
                e = exp_a.pop_front();
                chk("a_grant", 32'(a.grant), 32'(1) << e);
                chk("a_data", 32'(a.fifo_data_in), 32'h A0 + 32'(e));
            end
        end
        if (b.fifo_push) begin
            if (exp_b.size() == 0) chk("b_unexpected_push", 32'(b.grant), 32'h0);
            else begin
                e = exp_b.pop_front();
                chk("b_grant", 32'(b.grant), 32'(1) << e);
                chk("b_data", 32'(b.fifo_data_in), 32'h B0 + 32'(e));
            end
        end
        pend_push = a.fifo_push;
        pend_data = a.fifo_data_in;
        pend_pop = poll && fq.size() > 0;
    end

    always @(posedge clk) begin
        int e;
        if (pend_pop) begin
            if (exp_out.size() == 0) chk("fifo_unexpected_out", 32'(fq.pop_front()), 32'h0);
            else begin
                e = exp_out.pop_front();
                chk("fifo_out", 32'(fq.pop_front()), 32'h A0 + 32'(e));
            end
        end
        if (pend_push && !full_r) fq.push_back(pend_data);
        full_r <= fq.size() == 3;
    end

    initial begin
        rst = 1'b1;
        a.req = 4'b1111;
        b.req = 4'b1010;
        step(2);
        @(negedge clk);
        chk("rst_grant_a", 32'(a.grant), 32'h0);
        chk("rst_owner_valid", 32'(a.owner_valid), 32'h0);
        chk("rst_owner", 32'(a.owner), 32'h0);
        chk("rst_grant_b", 32'(b.grant), 32'h0);
        step(1);
        b.req = 4'b0000;
        plan(0, 10, 64'h0011223300);
        rst = 1'b0;
        step(10);
        a.req = 4'b0000;
        step(3);

        plan(0, 4, 64'h2222);
        a.req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lone_owner_valid", 32'(a.owner_valid), 32'(i % 2));
            chk("lone_owner", 32'(a.owner), i % 2 ? 32'h2 : 32'h0);
            step(1);
        end
        a.req = 4'b0000;
        step(3);

        poll = 1'b0;
        plan(0, 4, 64'h0011);
        a.req = 4'b0011;
        step(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_flag", 32'(a.fifo_full), 32'h1);
            chk("full_grant", 32'(a.grant), 32'h0);
            chk("full_owner", 32'(a.owner), 32'h1);
            step(1);
        end
        poll = 1'b1;
        step(2);
        a.req = 4'b0000;
        step(6);

        plan(0, 5, 64'h00133);
        a.req = 4'b0001;
        step(2);
        a.req = 4'b1010;
        step(1);
        a.req = 4'b1000;
        @(negedge clk);
        chk("handover_no_bubble", 32'(a.grant), 32'h8);
        step(2);
        a.req = 4'b0000;
        step(3);

        plan(0, 7, 64'h0011200);
        a.req = 4'b1111;
        step(5);
        rst = 1'b1;
        @(negedge clk);
        chk("midburst_owner", 32'(a.owner), 32'h2);
        chk("midburst_rst_grant", 32'(a.grant), 32'h0);
        chk("midburst_rst_push", 32'(a.fifo_push), 32'h0);
        step(1);
        rst = 1'b0;
        step(2);
        a.req = 4'b0000;
        step(3);

        plan(1, 4, 64'h1313);
        b.req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mb1_owner_valid", 32'(b.owner_valid), 32'h0);
            step(1);
        end
        b.req = 4'b0000;
        step(3);

        chk("a_grants_left", 32'(exp_a.size()), 32'h0);
        chk("b_grants_left", 32'(exp_b.size()), 32'h0);
        chk("fifo_out_left", 32'(exp_out.size()), 32'h0);
        chk("fifo_entries_left", 32'(fq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
